// File: rtl/jtcps1_prog_sdram_if.sv
// ROM download prog_* port: the writer drives one byte request and holds
// prog_we until the responder pulses sdram_ack.
interface jtcps1_prog_sdram_if;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_bank;
  logic        prog_we;
  logic        sdram_ack;

  modport master (output prog_addr, prog_data, prog_mask, prog_bank, prog_we,
                  input  sdram_ack);
  modport slave  (input  prog_addr, prog_data, prog_mask, prog_bank, prog_we,
                  output sdram_ack);
endinterface

// File: rtl/jtcps1_prog_sdram.sv
// SDRAM responder for the ROM download port: power-up init, one byte write
// per request (ACT + WRITE with autoprecharge) and periodic auto-refresh.
// All SDRAM pins are registered; they are decoded from the next state so the
// pins stay aligned with state_q.
// Optional: JTCPS1_FAST_INIT_EN shortens the power-up wait to 16 cycles.
module jtcps1_prog_sdram #(
  parameter int INIT_CYCLES    = 4800,
  parameter int TRCD           = 2,
  parameter int TWRP           = 4,
  parameter int TRFC           = 7,
  parameter int REFRESH_CYCLES = 374
) (
  input  logic                   clk,
  input  logic                   rst_n,
  jtcps1_prog_sdram_if.slave     prog,
  output logic                   init_done,
  output logic [12:0]            sdram_a,
  output logic [1:0]             sdram_ba,
  output logic [15:0]            sdram_dq_o,
  output logic                   sdram_dq_oe,
  output logic [1:0]             sdram_dqm,
  output logic                   sdram_ncs,
  output logic                   sdram_nras,
  output logic                   sdram_ncas,
  output logic                   sdram_nwe,
  output logic                   sdram_cke
);

`ifdef JTCPS1_FAST_INIT_EN
  localparam int INIT_LEN = 16;
`else
  localparam int INIT_LEN = INIT_CYCLES;
`endif
  // PRECHARGE ALL gets tRP=2; the MRS slot covers MRS, tMRD and two idle cycles
  localparam int TRP  = 2;
  localparam int TMRS = 4;
  localparam int CW   = 16;

  // {ncs, nras, ncas, nwe}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;

  typedef enum logic [3:0] {
    INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS,
    IDLE, ACT, WRITE, REF
  } state_t;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
    logic [1:0]  bank;
  } req_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   rcnt_q, rcnt_d;
  logic            pend_q, pend_d;
  logic            done_q, done_d;
  req_t            req_q, req_d;
  logic            expire;

  logic            cke_q, cke_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [12:0]     a_q, a_d;
  logic [1:0]      ba_q, ba_d;
  logic [15:0]     dq_q, dq_d;
  logic            oe_q, oe_d;
  logic [1:0]      dqm_q, dqm_d;
  logic            ack_q, ack_d;

  // Next state, per-state cycle count, request latch and refresh bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    req_d   = req_q;
    case (state_q)
      INIT_WAIT: if (cnt_q == CW'(INIT_LEN - 1)) begin state_d = INIT_PRE;  cnt_d = '0; end
      INIT_PRE:  if (cnt_q == CW'(TRP - 1))      begin state_d = INIT_REF1; cnt_d = '0; end
      INIT_REF1: if (cnt_q == CW'(TRFC - 1))     begin state_d = INIT_REF2; cnt_d = '0; end
      INIT_REF2: if (cnt_q == CW'(TRFC - 1))     begin state_d = INIT_MRS;  cnt_d = '0; end
      INIT_MRS:  if (cnt_q == CW'(TMRS - 1))     begin state_d = IDLE;      cnt_d = '0; end
      IDLE: begin
        cnt_d = '0;
        if (pend_q) state_d = REF;
        else if (prog.prog_we) begin
          state_d = ACT;
          req_d   = '{addr: prog.prog_addr, data: prog.prog_data,
                      mask: prog.prog_mask, bank: prog.prog_bank};
        end
      end
      ACT:   if (cnt_q == CW'(TRCD - 1)) begin state_d = WRITE; cnt_d = '0; end
      // WRITE slot plus TWRP cycles of write recovery / autoprecharge
      WRITE: if (cnt_q == CW'(TWRP))     begin state_d = IDLE;  cnt_d = '0; end
      REF:   if (cnt_q == CW'(TRFC - 1)) begin state_d = IDLE;  cnt_d = '0; end
      default: begin state_d = INIT_WAIT; cnt_d = '0; end
    endcase

    expire = done_q && (rcnt_q == CW'(REFRESH_CYCLES - 1));
    rcnt_d = (!done_q || expire) ? '0 : rcnt_q + 1'b1;
    // a fresh expiry wins over the clear; a repeat expiry while pending is absorbed
    pend_d = expire | (pend_q & ~((state_q == IDLE) & pend_q));
    done_d = done_q | (state_d == IDLE);
  end

  // Pin decode: the command is issued on the first cycle of its state
  always_comb begin
    cke_d = 1'b1;
    cmd_d = CMD_NOP;
    a_d   = '0;
    ba_d  = '0;
    dq_d  = '0;
    oe_d  = 1'b0;
    dqm_d = 2'b11;
    ack_d = 1'b0;
    if (cnt_d == '0) begin
      case (state_d)
        INIT_PRE: begin cmd_d = CMD_PRE; a_d[10] = 1'b1; end
        INIT_REF1, INIT_REF2, REF: cmd_d = CMD_REF;
        INIT_MRS: begin cmd_d = CMD_MRS; a_d = 13'h220; end
        ACT: begin
          cmd_d = CMD_ACT;
          ba_d  = req_d.bank;
          a_d   = req_d.addr[21:9];
        end
        WRITE: begin
          cmd_d = CMD_WR;
          ba_d  = req_d.bank;
          a_d   = {2'b00, 1'b1, 1'b0, req_d.addr[8:0]};
          dq_d  = {req_d.data, req_d.data};
          oe_d  = 1'b1;
          dqm_d = req_d.mask;
          ack_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State, counters and registered SDRAM pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_WAIT;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= '0;
      cke_q   <= 1'b0;
      cmd_q   <= CMD_NOP;
      a_q     <= '0;
      ba_q    <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      dqm_q   <= 2'b11;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      req_q   <= req_d;
      cke_q   <= cke_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      ba_q    <= ba_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      dqm_q   <= dqm_d;
      ack_q   <= ack_d;
    end
  end

  assign {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} = cmd_q;
  assign sdram_cke      = cke_q;
  assign sdram_a        = a_q;
  assign sdram_ba       = ba_q;
  assign sdram_dq_o     = dq_q;
  assign sdram_dq_oe    = oe_q;
  assign sdram_dqm      = dqm_q;
  assign prog.sdram_ack = ack_q;
  assign init_done      = done_q;

endmodule

// File: tb/tb_jtcps1_prog_sdram.sv
// Bench for jtcps1_prog_sdram: a command-schedule model predicts the SDRAM
// pins on every cycle; directed scenarios pin the model with literal timings.
module tb_jtcps1_prog_sdram;
  localparam int INIT_N = 16;
  localparam int TRCD   = 2;
  localparam int TWRP   = 4;
  localparam int TRFC   = 7;
  localparam int RFSH   = 374;
  localparam int D      = INIT_N + 2*TRFC + 6;   // first cycle with init_done=1

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtcps1_prog_sdram_if pif();
  logic        init_done, dq_oe, ncs, nras, ncas, nwe, cke;
  logic [12:0] a;
  logic [1:0]  ba, dqm;
  logic [15:0] dq_o;

  jtcps1_prog_sdram #(.INIT_CYCLES(INIT_N), .TRCD(TRCD), .TWRP(TWRP),
                      .TRFC(TRFC), .REFRESH_CYCLES(RFSH)) u_dut (
    .clk(clk), .rst_n(rst_n), .prog(pif), .init_done(init_done),
    .sdram_a(a), .sdram_ba(ba), .sdram_dq_o(dq_o), .sdram_dq_oe(dq_oe),
    .sdram_dqm(dqm), .sdram_ncs(ncs), .sdram_nras(nras), .sdram_ncas(ncas),
    .sdram_nwe(nwe), .sdram_cke(cke));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- model: schedule of commands by cycle ----------------
  int cyc = 0;           // cycles since reset release
  int next_free = D;     // next cycle the responder can take a decision
  bit pend = 0;
  logic [3:0]  e_cmd [int];
  logic [12:0] e_a   [int];
  logic [1:0]  e_ba  [int];
  logic [7:0]  e_d   [int];
  logic [1:0]  e_m   [int];

  function automatic logic [3:0] init_cmd(input int c);
    if (c == INIT_N)              return C_PRE;
    if (c == INIT_N + 2)          return C_REF;
    if (c == INIT_N + 2 + TRFC)   return C_REF;
    if (c == INIT_N + 2 + 2*TRFC) return C_MRS;
    return C_NOP;
  endfunction

  // At the end of each cycle: refresh requests, arbitration, schedule commands
  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0; next_free = D; pend = 0;
      e_cmd.delete(); e_a.delete(); e_ba.delete(); e_d.delete(); e_m.delete();
    end else begin
      if (cyc > D && (cyc - D) % RFSH == 0) pend = 1;
      if (cyc >= D && cyc == next_free) begin
        if (pend) begin
          e_cmd[cyc+1] = C_REF;
          pend = 0;
          next_free = cyc + 1 + TRFC;
        end else if (pif.prog_we) begin
          int w;
          w = cyc + 1 + TRCD;
          e_cmd[cyc+1] = C_ACT;
          e_ba[cyc+1]  = pif.prog_bank;
          e_a[cyc+1]   = pif.prog_addr[21:9];
          e_cmd[w] = C_WR;
          e_ba[w]  = pif.prog_bank;
          e_a[w]   = {2'b00, 1'b1, 1'b0, pif.prog_addr[8:0]};
          e_d[w]   = pif.prog_data;
          e_m[w]   = pif.prog_mask;
          next_free = w + TWRP + 1;
        end else next_free = cyc + 1;
      end
      cyc++;
    end
  end

  // ---------------- observations used by directed checks ----------------
  int t_pre = -1, t_done = -1, t_ref = -1, t_act = -1, t_ack = -1;
  int ack_cnt = 0, ack_gap = 0;
  logic [12:0] act_a, wr_a;
  logic [1:0]  act_ba, wr_dqm;
  logic [15:0] wr_dq;

  // Compare DUT pins against the model every cycle, mid-cycle
  always @(negedge clk) begin
    logic [3:0] got, ec;
    bit ok;
    got = {ncs, nras, ncas, nwe};
    if (!rst_n) begin
      ok = (cke == 0) && (got == C_NOP) && (a == 0) && (ba == 0) && (dqm == 2'b11)
           && (dq_oe == 0) && (pif.sdram_ack == 0) && (init_done == 0);
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL reset_pins: cke=%b cmd=%b a=%h ba=%h dqm=%b oe=%b ack=%b done=%b, required 0 0111 0 0 11 0 0 0",
                 cke, got, a, ba, dqm, dq_oe, pif.sdram_ack, init_done);
      end
      t_pre = -1; t_done = -1;
    end else begin
      ec = (cyc < D) ? init_cmd(cyc) : (e_cmd.exists(cyc) ? e_cmd[cyc] : C_NOP);
      ok = (got == ec) && (cke == (cyc >= 1)) && (init_done == (cyc >= D))
           && (pif.sdram_ack == (ec == C_WR)) && (dq_oe == (ec == C_WR));
      if (ec == C_PRE) ok = ok && a[10];
      if (ec == C_MRS) ok = ok && (a == 13'h220);
      if (ec == C_ACT) ok = ok && (a == e_a[cyc]) && (ba == e_ba[cyc]);
      if (ec == C_WR)
        ok = ok && (a == e_a[cyc]) && (ba == e_ba[cyc]) && (dqm == e_m[cyc])
                && (dq_o == {e_d[cyc], e_d[cyc]});
      else ok = ok && (dqm == 2'b11);
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL cycle_%0d: cmd=%b cke=%b done=%b ack=%b oe=%b a=%h ba=%h dqm=%b dq=%h, required cmd=%b",
                 cyc, got, cke, init_done, pif.sdram_ack, dq_oe, a, ba, dqm, dq_o, ec);
      end
      if (got == C_PRE && t_pre < 0) t_pre = cyc;
      if (init_done && t_done < 0) t_done = cyc;
      if (got == C_REF) t_ref = cyc;
      if (got == C_ACT) begin t_act = cyc; act_a = a; act_ba = ba; end
      if (pif.sdram_ack) begin
        ack_cnt++; ack_gap = cyc - t_ack; t_ack = cyc;
        wr_a = a; wr_dq = dq_o; wr_dqm = dqm;
      end
    end
  end

  // ---------------- writer helpers ----------------
  task automatic wait_ack(input int lim, input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < lim && !seen; k++) begin
      @(posedge clk); #2;
      if (pif.sdram_ack) seen = 1;
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no ack within %0d cycles, required one", name, lim);
    end
  endtask

  task automatic put(input logic [21:0] ad, input logic [7:0] d,
                     input logic [1:0] m, input logic [1:0] b, input string name);
    pif.prog_addr = ad; pif.prog_data = d; pif.prog_mask = m; pif.prog_bank = b;
    pif.prog_we = 1'b1;
    wait_ack(60, name);
    pif.prog_we = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic wait_cyc(input int n);
    do begin @(posedge clk); #2; end while (cyc < n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int saved;
    // write request held from reset: ignored until init completes
    pif.prog_addr = 22'h12345; pif.prog_data = 8'hA5;
    pif.prog_mask = 2'b10;     pif.prog_bank = 2'b10; pif.prog_we = 1'b1;
    repeat (3) begin @(posedge clk); #2; end
    check("rst_cke", cke, 0);
    check("rst_dqm", dqm, 2'b11);
    rst_n = 1'b1;
    wait_ack(100, "first_ack");
    pif.prog_we = 1'b0;
    @(posedge clk); #2;
    check("init_pre_cycle", t_pre, 16);
    check("init_done_cycle", t_done, 36);
    check("first_act_cycle", t_act, 37);
    check("first_ack_cycle", t_ack, 39);
    check("act_ba", act_ba, 2'b10);
    check("act_row", act_a, 13'h091);
    check("wr_addr", wr_a, 13'h0545);
    check("wr_dq", wr_dq, 16'hA5A5);
    check("wr_dqm", wr_dqm, 2'b10);
    check("ack_count_1", ack_cnt, 1);

    // back-to-back writes, writer drops we on ack
    for (int i = 0; i < 8; i++) begin
      logic [7:0] ib;
      ib = 8'(i);
      put(22'h30000 + 22'(i) * 22'h1234, 8'h10 + ib * 8'h11,
          ib[0] ? 2'b01 : 2'b10, ib[1:0], "b2b_ack");
      check("b2b_gap", ack_gap, 1 + TRCD + TWRP + 1);
    end
    check("ack_count_9", ack_cnt, 9);

    // refresh pending in the same IDLE cycle as a write request
    wait_cyc(D + RFSH);
    put(22'h2ABCD, 8'h5A, 2'b01, 2'b01, "rfsh_collide_ack");
    check("collide_ref_cycle", t_ref, 411);
    check("collide_act_cycle", t_act, 411 + TRFC + 1);

    // refresh expiring mid-write; we drops right after ACT
    wait_cyc(780);
    pif.prog_addr = 22'h01FF; pif.prog_data = 8'hC3;
    pif.prog_mask = 2'b10;    pif.prog_bank = 2'b11; pif.prog_we = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    pif.prog_we = 1'b0;
    wait_ack(10, "drop_after_act_ack");
    wait_cyc(795);
    check("midwr_act_cycle", t_act, 781);
    check("midwr_ack_cycle", t_ack, 783);
    check("midwr_ref_cycle", t_ref, 789);

    // reset one cycle after ACT aborts the write and reruns init
    saved = ack_cnt;
    wait_cyc(800);
    pif.prog_addr = 22'h3FFFF; pif.prog_data = 8'h77;
    pif.prog_mask = 2'b01;     pif.prog_bank = 2'b00; pif.prog_we = 1'b1;
    wait_cyc(802);
    rst_n = 1'b0; pif.prog_we = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    check("abort_cke", cke, 0);
    check("abort_cmd", {ncs, nras, ncas, nwe}, C_NOP);
    check("abort_oe", dq_oe, 0);
    check("abort_done", init_done, 0);
    rst_n = 1'b1;
    wait_cyc(40);
    check("abort_no_ack", ack_cnt, saved);
    check("reinit_pre_cycle", t_pre, 16);
    check("reinit_done_cycle", t_done, 36);
    put(22'h00010, 8'h99, 2'b10, 2'b01, "post_reinit_ack");
    check("post_reinit_ack_cycle", t_ack, 43);
    check("post_reinit_count", ack_cnt, saved + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
